branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_predict_unit.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction unit: a direct-mapped 2-bit counter table with BTB
// targets feeds the fetch-side prediction, while the execute side resolves control ops.
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [XLEN-1:0]  i_f_pc,
    output logic             o_f_pred_taken,
    output logic [XLEN-1:0]  o_f_pred_pc,
    input  logic             i_ex_valid,
    input  logic [XLEN-1:0]  i_ex_pc,
    input  logic [6:0]       i_ex_opcode,
    input  logic [2:0]       i_ex_func_3,
    input  logic [11:0]      i_imm_12_i,
    input  logic [19:0]      i_imm_20,
    input  logic [11:0]      i_imm_12_b,
    input  logic [XLEN-1:0]  i_rs_1,
    input  logic [XLEN-1:0]  i_rs_2,
    input  logic             i_ex_pred_taken,
    input  logic [XLEN-1:0]  i_ex_pred_pc,
    input  logic             i_stall,
    output logic             o_b_valid,
    output logic             o_b_taken,
    output logic [XLEN-1:0]  o_b_pc,
    output logic [XLEN-1:0]  o_link,
    output logic             o_mispredict,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [1:0]           cnt_q       [BHT_DEPTH];
    logic [XLEN-1:0]      btbTarget_q [BHT_DEPTH];
    logic [BHT_DEPTH-1:0] btbValid_q;

    logic             bValid_q, bTaken_q, mispred_q, illegal_q;
    logic [XLEN-1:0]  bPc_q, link_q, redirect_q;
    logic [CNT_W-1:0] mispredCnt_q, mispredCnt_d;

    logic [IDX_W-1:0] fIdx, exIdx;
    logic             isJal, isJalr, isBranch, isCtrl;
    logic             f3Illegal, brIllegal, brCond;
    logic             exTaken, exMispred, resValid, tblUpdate;
    logic [XLEN-1:0]  immI, immB, immJ, exTarget, exLink, exRedirect;

    assign fIdx           = i_f_pc[IDX_W+1:2];
    assign o_f_pred_taken = btbValid_q[fIdx] & cnt_q[fIdx][1];
    assign o_f_pred_pc    = o_f_pred_taken ? btbTarget_q[fIdx] : i_f_pc + XLEN'(4);

    assign immI = {{(XLEN-12){i_imm_12_i[11]}}, i_imm_12_i};
    assign immB = {{(XLEN-13){i_imm_12_b[11]}}, i_imm_12_b, 1'b0};
    assign immJ = {{(XLEN-21){i_imm_20[19]}}, i_imm_20, 1'b0};

    assign isJal    = (i_ex_opcode == OP_JAL);
    assign isJalr   = (i_ex_opcode == OP_JALR);
    assign isBranch = (i_ex_opcode == OP_BRANCH);
    assign isCtrl   = isJal | isJalr | isBranch;
    assign exIdx    = i_ex_pc[IDX_W+1:2];
    assign exLink   = i_ex_pc + XLEN'(4);

    always_comb begin
        brCond    = 1'b0;
        f3Illegal = 1'b0;
        case (i_ex_func_3)
            3'b000:  brCond = (i_rs_1 == i_rs_2);
            3'b001:  brCond = (i_rs_1 != i_rs_2);
            3'b100:  brCond = ($signed(i_rs_1) <  $signed(i_rs_2));
            3'b101:  brCond = ($signed(i_rs_1) >= $signed(i_rs_2));
            3'b110:  brCond = (i_rs_1 <  i_rs_2);
            3'b111:  brCond = (i_rs_1 >= i_rs_2);
            default: f3Illegal = 1'b1;
        endcase
    end

    // Resolve target and direction; illegal branches never count as taken or mispredicted
    always_comb begin
        brIllegal = isBranch & f3Illegal;
        exTaken   = isJal | isJalr | (isBranch & brCond & ~f3Illegal);
        if (isJalr) begin
            exTarget = (i_rs_1 + immI) & ~XLEN'(1);
        end else if (isJal) begin
            exTarget = i_ex_pc + immJ;
        end else begin
            exTarget = i_ex_pc + immB;
        end
        exRedirect = exTaken ? exTarget : exLink;
        exMispred  = isCtrl & ~brIllegal &
                     ((exTaken != i_ex_pred_taken) ||
                      (exTaken && i_ex_pred_taken && (exTarget != i_ex_pred_pc)));
        resValid   = i_ex_valid & isCtrl;
        tblUpdate  = resValid & ~i_stall & ~brIllegal;
    end

    always_comb begin
        mispredCnt_d = mispredCnt_q;
        if (resValid && exMispred && (mispredCnt_q != '1)) begin
            mispredCnt_d = mispredCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bValid_q     <= 1'b0;
            bTaken_q     <= 1'b0;
            bPc_q        <= '0;
            link_q       <= '0;
            mispred_q    <= 1'b0;
            redirect_q   <= '0;
            illegal_q    <= 1'b0;
            mispredCnt_q <= '0;
        end else if (!i_stall) begin
            bValid_q     <= resValid;
            bTaken_q     <= resValid & exTaken;
            bPc_q        <= resValid ? exTarget : '0;
            link_q       <= resValid ? exLink : '0;
            mispred_q    <= resValid & exMispred;
            redirect_q   <= resValid ? exRedirect : '0;
            illegal_q    <= resValid & brIllegal;
            mispredCnt_q <= mispredCnt_d;
        end
    end

    // Counters start weakly not-taken; a not-taken resolution never touches the BTB entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                cnt_q[i] <= 2'b01;
            end
            btbValid_q <= '0;
        end else if (tblUpdate) begin
            if (exTaken) begin
                cnt_q[exIdx]      <= (cnt_q[exIdx] == 2'b11) ? 2'b11 : cnt_q[exIdx] + 2'b01;
                btbValid_q[exIdx] <= 1'b1;
            end else if (isBranch) begin
                cnt_q[exIdx] <= (cnt_q[exIdx] == 2'b00) ? 2'b00 : cnt_q[exIdx] - 2'b01;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (tblUpdate && exTaken) begin
            btbTarget_q[exIdx] <= exTarget;
        end
    end

    assign o_b_valid     = bValid_q;
    assign o_b_taken     = bTaken_q;
    assign o_b_pc        = bPc_q;
    assign o_link        = link_q;
    assign o_mispredict  = mispred_q;
    assign o_redirect_pc = redirect_q;
    assign o_illegal     = illegal_q;
    assign o_mispred_cnt = mispredCnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios plus a randomized
// back-to-back stream, each result checked one cycle after its issue edge.
module tb_branch_predict_unit;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct {
        int          due;
        logic        taken;
        logic [31:0] bpc;
        logic [31:0] link;
        logic [31:0] redirect;
        logic        mispred;
        logic        illegal;
        logic        chkTgt;
        logic [31:0] cnt;
    } expT;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_f_pc;
    logic        o_f_pred_taken;
    logic [31:0] o_f_pred_pc;
    logic        i_ex_valid;
    logic [31:0] i_ex_pc;
    logic [6:0]  i_ex_opcode;
    logic [2:0]  i_ex_func_3;
    logic [11:0] i_imm_12_i;
    logic [19:0] i_imm_20;
    logic [11:0] i_imm_12_b;
    logic [31:0] i_rs_1, i_rs_2;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_pc;
    logic        i_stall;
    logic        o_b_valid, o_b_taken, o_mispredict, o_illegal;
    logic [31:0] o_b_pc, o_link, o_redirect_pc, o_mispred_cnt;

    expT         expQ[$];
    expT         mon;
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    bit          holdOk = 1'b0;
    logic [31:0] expMisCnt = '0;

    branch_predict_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_f_pc(i_f_pc), .o_f_pred_taken(o_f_pred_taken), .o_f_pred_pc(o_f_pred_pc),
        .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_ex_opcode(i_ex_opcode),
        .i_ex_func_3(i_ex_func_3), .i_imm_12_i(i_imm_12_i), .i_imm_20(i_imm_20),
        .i_imm_12_b(i_imm_12_b), .i_rs_1(i_rs_1), .i_rs_2(i_rs_2),
        .i_ex_pred_taken(i_ex_pred_taken), .i_ex_pred_pc(i_ex_pred_pc), .i_stall(i_stall),
        .o_b_valid(o_b_valid), .o_b_taken(o_b_taken), .o_b_pc(o_b_pc), .o_link(o_link),
        .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc), .o_illegal(o_illegal),
        .o_mispred_cnt(o_mispred_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Independent reference for a single execute-stage control op
    function automatic expT model(input logic [31:0] pc, input logic [6:0] op,
                                  input logic [2:0] f3, input logic [11:0] immI,
                                  input logic [19:0] imm20, input logic [11:0] immB,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic pt, input logic [31:0] ppc);
        expT e;
        logic tk, ill;
        logic [31:0] tgt;
        tk  = 1'b0;
        ill = 1'b0;
        tgt = pc + {{19{immB[11]}}, immB, 1'b0};
        if (op == OP_JAL) begin
            tk  = 1'b1;
            tgt = pc + {{11{imm20[19]}}, imm20, 1'b0};
        end else if (op == OP_JALR) begin
            tk  = 1'b1;
            tgt = (rs1 + {{20{immI[11]}}, immI}) & 32'hFFFF_FFFE;
        end else begin
            case (f3)
                3'd0:    tk = (rs1 == rs2);
                3'd1:    tk = (rs1 != rs2);
                3'd4:    tk = ($signed(rs1) <  $signed(rs2));
                3'd5:    tk = ($signed(rs1) >= $signed(rs2));
                3'd6:    tk = (rs1 <  rs2);
                3'd7:    tk = (rs1 >= rs2);
                default: ill = 1'b1;
            endcase
        end
        e.due      = 0;
        e.cnt      = '0;
        e.taken    = tk;
        e.bpc      = tgt;
        e.link     = pc + 32'd4;
        e.redirect = tk ? tgt : pc + 32'd4;
        e.illegal  = ill;
        e.chkTgt   = !ill;
        e.mispred  = !ill && ((tk != pt) || (tk && (tgt != ppc)));
        return e;
    endfunction

    function automatic expT mk(input logic tk, input logic [31:0] bpc, input logic [31:0] link,
                               input logic [31:0] redirect, input logic mis, input logic ill);
        expT e;
        e.due      = 0;
        e.cnt      = '0;
        e.taken    = tk;
        e.bpc      = bpc;
        e.link     = link;
        e.redirect = redirect;
        e.mispred  = mis;
        e.illegal  = ill;
        e.chkTgt   = 1'b1;
        return e;
    endfunction

    // Drive one op at the falling edge, queue its expectation, return just after the sampling edge
    task automatic applyStimulus(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [11:0] immI, input logic [19:0] imm20,
                                 input logic [11:0] immB, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic pt, input logic [31:0] ppc,
                                 input expT e);
        expT q;
        @(negedge i_clk);
        i_ex_valid      = 1'b1;
        i_ex_pc         = pc;
        i_ex_opcode     = op;
        i_ex_func_3     = f3;
        i_imm_12_i      = immI;
        i_imm_20        = imm20;
        i_imm_12_b      = immB;
        i_rs_1          = rs1;
        i_rs_2          = rs2;
        i_ex_pred_taken = pt;
        i_ex_pred_pc    = ppc;
        q = e;
        if (q.mispred) expMisCnt = expMisCnt + 32'd1;
        q.cnt = expMisCnt;
        q.due = cycle + 1;
        expQ.push_back(q);
        @(posedge i_clk);
        #2;
    endtask

    // Scoreboard monitor: each queued result must appear exactly on its due edge
    always begin
        @(posedge i_clk);
        #1;
        cycle++;
        if (expQ.size() > 0 && expQ[0].due == cycle) begin
            mon = expQ.pop_front();
            checks += 6;
            if (o_b_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL sb_valid cyc %0d: got %b expected 1", cycle, o_b_valid);
            end
            if (o_b_taken !== mon.taken) begin
                errors++; $display("[TB] FAIL sb_taken cyc %0d: got %b expected %b", cycle, o_b_taken, mon.taken);
            end
            if (o_link !== mon.link) begin
                errors++; $display("[TB] FAIL sb_link cyc %0d: got %h expected %h", cycle, o_link, mon.link);
            end
            if (o_mispredict !== mon.mispred) begin
                errors++; $display("[TB] FAIL sb_mispred cyc %0d: got %b expected %b", cycle, o_mispredict, mon.mispred);
            end
            if (o_illegal !== mon.illegal) begin
                errors++; $display("[TB] FAIL sb_illegal cyc %0d: got %b expected %b", cycle, o_illegal, mon.illegal);
            end
            if (o_mispred_cnt !== mon.cnt) begin
                errors++; $display("[TB] FAIL sb_cnt cyc %0d: got %0d expected %0d", cycle, o_mispred_cnt, mon.cnt);
            end
            if (mon.chkTgt) begin
                checks += 2;
                if (o_b_pc !== mon.bpc) begin
                    errors++; $display("[TB] FAIL sb_bpc cyc %0d: got %h expected %h", cycle, o_b_pc, mon.bpc);
                end
                if (o_redirect_pc !== mon.redirect) begin
                    errors++; $display("[TB] FAIL sb_redirect cyc %0d: got %h expected %h", cycle, o_redirect_pc, mon.redirect);
                end
            end
        end else if (o_b_valid === 1'b1 && !holdOk) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_unexpected cyc %0d: o_b_valid got 1 expected 0", cycle);
        end
    end

    task automatic test_reset();
        #2 i_rst_n = 1'b0;
        #1;
        checks += 3;
        if (o_b_valid !== 1'b0 || o_b_taken !== 1'b0 || o_mispredict !== 1'b0 || o_illegal !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b%b%b%b expected 0000", o_b_valid, o_b_taken, o_mispredict, o_illegal);
        end
        if (o_b_pc !== 32'd0 || o_link !== 32'd0 || o_redirect_pc !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_pcs: got %h %h %h expected zeros", o_b_pc, o_link, o_redirect_pc);
        end
        if (o_mispred_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", o_mispred_cnt);
        end
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
    endtask

    task automatic test_fetch_default();
        i_f_pc = 32'h100;
        #1;
        checks += 2;
        if (o_f_pred_taken !== 1'b0) begin
            errors++; $display("[TB] FAIL fetch_taken: got %b expected 0", o_f_pred_taken);
        end
        if (o_f_pred_pc !== 32'h104) begin
            errors++; $display("[TB] FAIL fetch_pc: got %h expected 00000104", o_f_pred_pc);
        end
    endtask

    task automatic test_beq_training();
        logic expNt[4];
        expNt = '{1'b1, 1'b0, 1'b0, 1'b0};
        i_f_pc = 32'h200;
        #1;
        checks++;
        if (o_f_pred_taken !== 1'b0) begin
            errors++; $display("[TB] FAIL beq_pre_update: got %b expected 0", o_f_pred_taken);
        end
        applyStimulus(32'h200, OP_BRANCH, 3'b000, 12'h0, 20'h0, 12'hFFE, 32'd5, 32'd5, 1'b0, 32'h0,
                      mk(1'b1, 32'h1FC, 32'h204, 32'h1FC, 1'b1, 1'b0));
        repeat (2) applyStimulus(32'h200, OP_BRANCH, 3'b000, 12'h0, 20'h0, 12'hFFE, 32'd5, 32'd5, 1'b1, 32'h1FC,
                                 mk(1'b1, 32'h1FC, 32'h204, 32'h1FC, 1'b0, 1'b0));
        checks += 2;
        if (o_f_pred_taken !== 1'b1) begin
            errors++; $display("[TB] FAIL beq_strong_taken: got %b expected 1", o_f_pred_taken);
        end
        if (o_f_pred_pc !== 32'h1FC) begin
            errors++; $display("[TB] FAIL beq_pred_pc: got %h expected 000001fc", o_f_pred_pc);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'h200, OP_BRANCH, 3'b000, 12'h0, 20'h0, 12'hFFE, 32'd5, 32'd6, 1'b1, 32'h1FC,
                          mk(1'b0, 32'h1FC, 32'h204, 32'h204, 1'b1, 1'b0));
            checks++;
            if (o_f_pred_taken !== expNt[k]) begin
                errors++; $display("[TB] FAIL beq_nt_%0d: got %b expected %b", k, o_f_pred_taken, expNt[k]);
            end
        end
        applyStimulus(32'h200, OP_BRANCH, 3'b000, 12'h0, 20'h0, 12'hFFE, 32'd7, 32'd7, 1'b0, 32'h0,
                      mk(1'b1, 32'h1FC, 32'h204, 32'h1FC, 1'b1, 1'b0));
        checks++;
        if (o_f_pred_taken !== 1'b0) begin
            errors++; $display("[TB] FAIL beq_no_underflow: got %b expected 0", o_f_pred_taken);
        end
        applyStimulus(32'h200, OP_BRANCH, 3'b000, 12'h0, 20'h0, 12'hFFE, 32'd7, 32'd7, 1'b1, 32'h1FC,
                      mk(1'b1, 32'h1FC, 32'h204, 32'h1FC, 1'b0, 1'b0));
        checks++;
        if (o_f_pred_taken !== 1'b1) begin
            errors++; $display("[TB] FAIL beq_retrain: got %b expected 1", o_f_pred_taken);
        end
        applyStimulus(32'h200, OP_BRANCH, 3'b000, 12'h0, 20'h0, 12'hFFE, 32'd7, 32'd7, 1'b1, 32'h300,
                      mk(1'b1, 32'h1FC, 32'h204, 32'h1FC, 1'b1, 1'b0));
    endtask

    task automatic test_jalr_compare();
        applyStimulus(32'h300, OP_JALR, 3'b000, 12'hFFF, 20'h0, 12'h0, 32'h1001, 32'h0, 1'b0, 32'h0,
                      mk(1'b1, 32'h1000, 32'h304, 32'h1000, 1'b1, 1'b0));
        applyStimulus(32'h400, OP_BRANCH, 3'b110, 12'h0, 20'h0, 12'h010, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0,
                      mk(1'b0, 32'h420, 32'h404, 32'h404, 1'b0, 1'b0));
        applyStimulus(32'h400, OP_BRANCH, 3'b100, 12'h0, 20'h0, 12'h010, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0,
                      mk(1'b1, 32'h420, 32'h404, 32'h420, 1'b1, 1'b0));
    endtask

    task automatic test_jal_wrap_illegal();
        expT e;
        applyStimulus(32'hFFFF_FFFC, OP_JAL, 3'b000, 12'h0, 20'h2, 12'h0, 32'h0, 32'h0, 1'b1, 32'h0,
                      mk(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        i_f_pc = 32'h204;
        e = mk(1'b0, 32'h0, 32'h208, 32'h0, 1'b0, 1'b1);
        e.chkTgt = 1'b0;
        applyStimulus(32'h204, OP_BRANCH, 3'b010, 12'h0, 20'h0, 12'h008, 32'd7, 32'd7, 1'b1, 32'h208, e);
        checks += 2;
        if (o_f_pred_taken !== 1'b0) begin
            errors++; $display("[TB] FAIL illegal_no_update: got %b expected 0", o_f_pred_taken);
        end
        if (o_f_pred_pc !== 32'h208) begin
            errors++; $display("[TB] FAIL illegal_pred_pc: got %h expected 00000208", o_f_pred_pc);
        end
    endtask

    task automatic test_non_control();
        @(negedge i_clk);
        i_ex_valid  = 1'b1;
        i_ex_pc     = 32'h20C;
        i_ex_opcode = 7'b0110011;
        i_ex_func_3 = 3'b000;
        @(posedge i_clk);
        #2;
        checks++;
        if (o_b_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL noncontrol_valid: got %b expected 0", o_b_valid);
        end
        @(negedge i_clk);
        i_ex_valid = 1'b0;
        i_f_pc     = 32'h20C;
        #1;
        checks++;
        if (o_f_pred_taken !== 1'b0) begin
            errors++; $display("[TB] FAIL noncontrol_table: got %b expected 0", o_f_pred_taken);
        end
    endtask

    task automatic test_stall();
        applyStimulus(32'h500, OP_JAL, 3'b000, 12'h0, 20'h8, 12'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      mk(1'b1, 32'h510, 32'h504, 32'h510, 1'b1, 1'b0));
        @(negedge i_clk);
        holdOk          = 1'b1;
        i_stall         = 1'b1;
        i_ex_valid      = 1'b1;
        i_ex_pc         = 32'h208;
        i_ex_opcode     = OP_JAL;
        i_imm_20        = 20'h4;
        i_ex_pred_taken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #2;
            checks += 3;
            if (o_b_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL stall_valid_%0d: got %b expected 1", k, o_b_valid);
            end
            if (o_b_pc !== 32'h510 || o_link !== 32'h504) begin
                errors++; $display("[TB] FAIL stall_frozen_%0d: got %h/%h expected 00000510/00000504", k, o_b_pc, o_link);
            end
            if (o_mispred_cnt !== expMisCnt) begin
                errors++; $display("[TB] FAIL stall_cnt_%0d: got %0d expected %0d", k, o_mispred_cnt, expMisCnt);
            end
        end
        @(negedge i_clk);
        i_stall    = 1'b0;
        i_ex_valid = 1'b0;
        @(posedge i_clk);
        #2;
        holdOk = 1'b0;
        i_f_pc = 32'h208;
        #1;
        checks += 3;
        if (o_b_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_release_valid: got %b expected 0", o_b_valid);
        end
        if (o_f_pred_taken !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_no_update: got %b expected 0", o_f_pred_taken);
        end
        if (o_mispred_cnt !== expMisCnt) begin
            errors++; $display("[TB] FAIL stall_release_cnt: got %0d expected %0d", o_mispred_cnt, expMisCnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3Tab[7];
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc, rs1, rs2, ppc;
        logic [11:0] immI, immB;
        logic [19:0] imm20;
        logic        pt;
        int          kind;
        expT         e;
        f3Tab = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
        for (int n = 0; n < 30; n++) begin
            kind  = $urandom_range(0, 8);
            op    = (kind == 7) ? OP_JAL : (kind == 8) ? OP_JALR : OP_BRANCH;
            f3    = (kind < 7) ? f3Tab[kind] : 3'd0;
            pc    = $urandom() & 32'hFFFF_FFFC;
            rs1   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
            rs2   = ($urandom_range(0, 2) == 0) ? rs1 : $urandom();
            immI  = 12'($urandom());
            immB  = 12'($urandom());
            imm20 = 20'($urandom());
            pt    = 1'($urandom());
            e     = model(pc, op, f3, immI, imm20, immB, rs1, rs2, pt, 32'h0);
            ppc   = $urandom_range(0, 1) ? e.bpc : e.bpc + 32'd4;
            e     = model(pc, op, f3, immI, imm20, immB, rs1, rs2, pt, ppc);
            applyStimulus(pc, op, f3, immI, imm20, immB, rs1, rs2, pt, ppc, e);
        end
        @(negedge i_clk);
        i_ex_valid = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        applyStimulus(32'h600, OP_JAL, 3'b000, 12'h0, 20'h10, 12'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                      mk(1'b1, 32'h620, 32'h604, 32'h620, 1'b1, 1'b0));
        @(negedge i_clk);
        i_ex_valid      = 1'b1;
        i_ex_pc         = 32'h200;
        i_ex_opcode     = OP_BRANCH;
        i_ex_func_3     = 3'b000;
        i_imm_12_b      = 12'hFFE;
        i_rs_1          = 32'd9;
        i_rs_2          = 32'd9;
        i_ex_pred_taken = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        checks += 3;
        if (o_b_valid !== 1'b0 || o_b_taken !== 1'b0 || o_mispredict !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_flags: got %b%b%b expected 000", o_b_valid, o_b_taken, o_mispredict);
        end
        if (o_b_pc !== 32'd0 || o_link !== 32'd0 || o_redirect_pc !== 32'd0) begin
            errors++; $display("[TB] FAIL midreset_pcs: got %h %h %h expected zeros", o_b_pc, o_link, o_redirect_pc);
        end
        if (o_mispred_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL midreset_cnt: got %0d expected 0", o_mispred_cnt);
        end
        @(posedge i_clk);
        #2;
        i_f_pc = 32'h200;
        #1;
        checks += 2;
        if (o_b_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_discard: got %b expected 0", o_b_valid);
        end
        if (o_f_pred_taken !== 1'b0 || o_f_pred_pc !== 32'h204) begin
            errors++; $display("[TB] FAIL midreset_table: got %b/%h expected 0/00000204", o_f_pred_taken, o_f_pred_pc);
        end
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        expMisCnt = '0;
        applyStimulus(32'h200, OP_BRANCH, 3'b000, 12'h0, 20'h0, 12'hFFE, 32'd9, 32'd9, 1'b0, 32'h0,
                      mk(1'b1, 32'h1FC, 32'h204, 32'h1FC, 1'b1, 1'b0));
        @(negedge i_clk);
        i_ex_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_rst_n         = 1'b1;
        i_f_pc          = '0;
        i_ex_valid      = 1'b0;
        i_ex_pc         = '0;
        i_ex_opcode     = '0;
        i_ex_func_3     = '0;
        i_imm_12_i      = '0;
        i_imm_20        = '0;
        i_imm_12_b      = '0;
        i_rs_1          = '0;
        i_rs_2          = '0;
        i_ex_pred_taken = 1'b0;
        i_ex_pred_pc    = '0;
        i_stall         = 1'b0;
        test_reset();
        test_fetch_default();
        test_beq_training();
        test_jalr_compare();
        test_jal_wrap_illegal();
        test_non_control();
        test_stall();
        test_back_to_back();
        test_reset_mid_op();
        repeat (2) @(posedge i_clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++; $display("[TB] FAIL sb_drain: got %0d pending results expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
